// File: rtl/traffic_pkg.sv
`default_nettype none
// ==========================================================================
// traffic_pkg : shared constants, seconds type and controller state encoding
// Rev 1.0
// ==========================================================================
package traffic_pkg;

   localparam int DEF_T_A = 5;
   localparam int DEF_T_B = 15;
   localparam int DEF_T_C = 20;
   localparam int DEF_T_D = 50;

   localparam int SEC_W = 6;
   typedef logic [SEC_W-1:0] sec_t;
   localparam sec_t SEC_MAX = '1;

   typedef enum logic [1:0] {
      ST_MAIN_GREEN  = 2'd0,
      ST_MAIN_YELLOW = 2'd1,
      ST_SIDE_GREEN  = 2'd2,
      ST_SIDE_YELLOW = 2'd3
   } light_state_t;

   function automatic logic sec_hit(input sec_t s, input int t);
      return s == sec_t'(t);
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ==========================================================================
// btn_debounce : two-FF synchronizer, stability debouncer and press pulse
// Rev 1.0
// ==========================================================================
module btn_debounce #(
   parameter int DEB_CYCLES = 1250000
) (
   input  logic sysclk,
   input  logic rst,
   input  logic btn_raw,
   output logic db_level,
   output logic press
);

   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             state;
   logic [CNT_W-1:0] cnt;

   // Any sample matching the current state restarts the stability window.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         state <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 != state) begin
            if (cnt == CNT_LAST) begin
               state <= ~state;
               cnt   <= '0;
               press <= ~state;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign db_level = state;

endmodule
`default_nettype wire

// File: rtl/traffic_timer.sv
`default_nettype none
// ==========================================================================
// traffic_timer : 1 Hz prescaler, seconds counter, thresholds, ped request
// Rev 1.0
// ==========================================================================
module traffic_timer
   import traffic_pkg::*;
#(
   parameter int CLK_HZ     = 125000000,
   parameter int DEB_CYCLES = 1250000,
   parameter int T_A        = DEF_T_A,
   parameter int T_B        = DEF_T_B,
   parameter int T_C        = DEF_T_C,
   parameter int T_D        = DEF_T_D
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic             btn_raw,
   input  logic             zc,
   input  logic             req_ack,
   output logic             clk1hz,
   output logic             tick,
   output logic [SEC_W-1:0] sec_count,
   output logic             t5s,
   output logic             t15s,
   output logic             t20s,
   output logic             t50s,
   output logic             bt
);

   localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_HZ / 2);

   logic [DIV_W-1:0] div;
   sec_t             sec_next;
   logic             db_level;
   logic             press;

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         div    <= '0;
         clk1hz <= 1'b0;
         tick   <= 1'b0;
      end else begin
         div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
         clk1hz <= (div < DIV_HALF);
         tick   <= (div == '0);
      end
   end

   always_comb begin
      sec_next = sec_count;
      if (tick) begin
         if (zc) begin
            sec_next = '0;
         end else if (sec_count != SEC_MAX) begin
            sec_next = sec_count + 1'b1;
         end
      end
   end

   // Flags compare the next value so they move together with sec_count.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         sec_count <= '0;
         t5s       <= 1'b0;
         t15s      <= 1'b0;
         t20s      <= 1'b0;
         t50s      <= 1'b0;
      end else begin
         sec_count <= sec_next;
         t5s       <= sec_hit(sec_next, T_A);
         t15s      <= sec_hit(sec_next, T_B);
         t20s      <= sec_hit(sec_next, T_C);
         t50s      <= sec_hit(sec_next, T_D);
      end
   end

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_btn (
      .sysclk   (sysclk),
      .rst      (rst),
      .btn_raw  (btn_raw),
      .db_level (db_level),
      .press    (press)
   );

   // A press always coincides with the debounced level having just risen.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         bt <= 1'b0;
      end else if (press && db_level) begin
         bt <= 1'b1;
      end else if (req_ack) begin
         bt <= 1'b0;
      end
   end

endmodule
`default_nettype wire
